// File: rtl/mips_pkg.sv
// mips_pkg: shared FSM states, ALU codes and opcode/funct constants for the multicycle controller.
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXECUTE, S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP
    } state_e;

    typedef enum logic [1:0] {
        AOP_ADD   = 2'b00,
        AOP_SUB   = 2'b01,
        AOP_FUNCT = 2'b10
    } aluop_e;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    function automatic logic known_op(input logic [5:0] op);
        return op inside {OP_RTYPE, OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_LW, OP_SW};
    endfunction

endpackage

// File: rtl/mips_aludec.sv
// mips_aludec: ALUOp/funct to ALUControl decode; illegal_o flags an unsupported funct.
module mips_aludec
    import mips_pkg::*;
(
    input  aluop_e     alu_op_i,
    input  logic [5:0] funct_i,
    output logic [2:0] alu_ctrl_o,
    output logic       illegal_o
);

    logic [2:0] fn_ctrl;

    always_comb begin
        fn_ctrl   = ALU_ADD;
        illegal_o = 1'b0;
        case (funct_i)
            FN_ADD:  fn_ctrl = ALU_ADD;
            FN_SUB:  fn_ctrl = ALU_SUB;
            FN_AND:  fn_ctrl = ALU_AND;
            FN_OR:   fn_ctrl = ALU_OR;
            FN_SLT:  fn_ctrl = ALU_SLT;
            default: illegal_o = 1'b1;
        endcase
        alu_ctrl_o = alu_op_i == AOP_FUNCT ? fn_ctrl : alu_op_i == AOP_SUB ? ALU_SUB : ALU_ADD;
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multicycle MIPS control FSM with memory wait states and a retired-instruction counter.
module mips_multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       Op,
    input  logic [5:0]       Funct,
    input  logic             Zero,
    output logic             IorD,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       PCSrc,
    output logic [2:0]       ALUControl,
    output logic             PCEn,
    output logic             Illegal,
    output logic [CNT_W-1:0] Retired
);

    localparam logic [3:0] LAST = 4'(MEM_LAT - 1);

    state_e           state_q, state_d;
    logic [3:0]       wait_q, wait_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             last, retire, fn_bad, op_bad;
    aluop_e           alu_op;
    logic [2:0]       alu_ctrl;

    mips_aludec u_aludec (
        .alu_op_i  (alu_op),
        .funct_i   (Funct),
        .alu_ctrl_o(alu_ctrl),
        .illegal_o (fn_bad)
    );

    assign last      = wait_q == LAST;
    assign op_bad    = !known_op(Op) || (Op == OP_RTYPE && fn_bad);
    assign retire    = state_q inside {S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP} ||
                       (state_q == S_MEMWR && last);
    // Any state change clears the wait counter; only memory states ever linger.
    assign wait_d    = state_d == state_q ? wait_q + 4'd1 : 4'd0;
    assign retired_d = retired_q + CNT_W'(retire);
    assign alu_op    = state_q == S_EXECUTE ? AOP_FUNCT : state_q == S_BRANCH ? AOP_SUB : AOP_ADD;
    assign Retired   = retired_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            wait_q    <= 4'd0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:   state_d = last ? S_DECODE : S_FETCH;
            S_DECODE:  state_d = op_bad ? S_FETCH :
                                 Op inside {OP_LW, OP_SW} ? S_MEMADR :
                                 Op == OP_RTYPE ? S_EXECUTE :
                                 Op inside {OP_BEQ, OP_BNE} ? S_BRANCH :
                                 Op == OP_ADDI ? S_ADDIEX : S_JUMP;
            S_MEMADR:  state_d = Op == OP_LW ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_d = last ? S_MEMWB : S_MEMRD;
            S_MEMWR:   state_d = last ? S_FETCH : S_MEMWR;
            S_EXECUTE: state_d = S_ALUWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            default:   state_d = S_FETCH;
        endcase
    end

    always_comb begin
        IorD       = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        PCSrc      = 2'b00;
        ALUControl = 3'b000;
        PCEn       = 1'b0;
        Illegal    = 1'b0;
        case (state_q)
            S_FETCH: begin
                ALUSrcB    = 2'b01;
                ALUControl = alu_ctrl;
                IRWrite    = last && !reset;
                PCEn       = last && !reset;
            end
            S_DECODE: begin
                ALUSrcB    = 2'b11;
                ALUControl = alu_ctrl;
                Illegal    = op_bad;
            end
            S_MEMADR, S_ADDIEX: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUControl = alu_ctrl;
            end
            S_MEMRD: IorD = 1'b1;
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            S_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = last;
            end
            S_EXECUTE: begin
                ALUSrcA    = 1'b1;
                ALUControl = alu_ctrl;
            end
            S_ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUControl = alu_ctrl;
                PCSrc      = 2'b01;
                PCEn       = Op == OP_BEQ ? Zero : !Zero;
            end
            S_ADDIWB: RegWrite = 1'b1;
            S_JUMP: begin
                PCSrc = 2'b10;
                PCEn  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: three controllers (MEM_LAT 1..3, 4-bit counter) checked cycle by cycle against a per-instruction model.
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst[3];
    logic [5:0] op[3], funct[3];
    logic       zero[3];
    logic       iord[3], memwrite[3], irwrite[3], regdst[3], memtoreg[3], regwrite[3], alusrca[3], pcen[3], illegal[3];
    logic [1:0] alusrcb[3], pcsrc[3];
    logic [2:0] aluctl[3];
    logic [3:0] ret[3];
    logic [15:0] vec[3];

    logic [15:0] exp_q[$];
    logic [3:0]  mret[3];
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mips_multicycle_ctrl #(.MEM_LAT(g + 1), .CNT_W(4)) dut (
            .clk(clk), .reset(rst[g]), .Op(op[g]), .Funct(funct[g]), .Zero(zero[g]),
            .IorD(iord[g]), .MemWrite(memwrite[g]), .IRWrite(irwrite[g]), .RegDst(regdst[g]),
            .MemtoReg(memtoreg[g]), .RegWrite(regwrite[g]), .ALUSrcA(alusrca[g]),
            .ALUSrcB(alusrcb[g]), .PCSrc(pcsrc[g]), .ALUControl(aluctl[g]),
            .PCEn(pcen[g]), .Illegal(illegal[g]), .Retired(ret[g])
        );
        assign vec[g] = {iord[g], memwrite[g], irwrite[g], regdst[g], memtoreg[g], regwrite[g],
                         alusrca[g], alusrcb[g], pcsrc[g], aluctl[g], pcen[g], illegal[g]};
    end

    function automatic logic [15:0] mk(bit io, bit mw, bit irw, bit rd, bit m2r, bit rw, bit asa,
                                       logic [1:0] asb, logic [1:0] pcs, logic [2:0] alu, bit pe, bit ill);
        return {io, mw, irw, rd, m2r, rw, asa, asb, pcs, alu, pe, ill};
    endfunction

    localparam logic [15:0] RST_VEC = {7'b0, 2'b01, 2'b00, 3'b010, 1'b0, 1'b0};

    // Builds the full expected per-cycle control sequence of one instruction; returns whether it retires.
    function automatic bit model(int lat, logic [5:0] o, logic [5:0] f, bit z);
        logic [2:0] fa;
        bit fok;
        exp_q.delete();
        for (int i = 0; i < lat; i++)
            exp_q.push_back(mk(0, 0, i == lat - 1, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010, i == lat - 1, 0));
        fok = 1;
        case (f)
            6'h20: fa = 3'b010;
            6'h22: fa = 3'b110;
            6'h24: fa = 3'b000;
            6'h25: fa = 3'b001;
            6'h2A: fa = 3'b111;
            default: begin fa = 3'b000; fok = 0; end
        endcase
        if (!(o inside {6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h23, 6'h2B}) || (o == 6'h00 && !fok)) begin
            exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b010, 0, 1));
            return 0;
        end
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b010, 0, 0));
        if (o == 6'h23 || o == 6'h2B) begin
            exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b010, 0, 0));
            for (int i = 0; i < lat; i++)
                exp_q.push_back(mk(1, o == 6'h2B && i == lat - 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0, 0));
            if (o == 6'h23) exp_q.push_back(mk(0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 3'b000, 0, 0));
        end else if (o == 6'h00) begin
            exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, fa, 0, 0));
            exp_q.push_back(mk(0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 3'b000, 0, 0));
        end else if (o == 6'h04 || o == 6'h05) begin
            exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 3'b110, o == 6'h04 ? z : !z, 0));
        end else if (o == 6'h08) begin
            exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b010, 0, 0));
            exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 3'b000, 0, 0));
        end else begin
            exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 3'b000, 1, 0));
        end
        return 1;
    endfunction

    // Holds every controller in reset, then releases only controller d at a fresh FETCH.
    task automatic select(int d);
        @(negedge clk);
        for (int k = 0; k < 3; k++) rst[k] = 1'b1;
        #1;
        vectors++;
        if (vec[d] !== RST_VEC || ret[d] !== 4'd0) begin
            miscompares++;
            $display("FAIL reset d%0d: got ctl=%b ret=%0d expected ctl=%b ret=0", d, vec[d], ret[d], RST_VEC);
        end
        mret[d] = 4'd0;
        @(posedge clk);
        #1 rst[d] = 1'b0;
    endtask

    task automatic run_instr(string name, int d, logic [5:0] o, logic [5:0] f, bit z, int abort_at);
        bit retires;
        retires = model(d + 1, o, f, z);
        foreach (exp_q[i]) begin
            @(negedge clk);
            op[d] = o; funct[d] = f; zero[d] = z;
            if (i == abort_at) begin
                rst[d] = 1'b1;
                #1;
                vectors++;
                if (vec[d] !== RST_VEC || ret[d] !== 4'd0) begin
                    miscompares++;
                    $display("FAIL %s abort d%0d: got ctl=%b ret=%0d expected ctl=%b ret=0", name, d, vec[d], ret[d], RST_VEC);
                end
                mret[d] = 4'd0;
                return;
            end
            #1;
            vectors++;
            if (vec[d] !== exp_q[i] || ret[d] !== mret[d]) begin
                miscompares++;
                $display("FAIL %s d%0d cycle%0d: got ctl=%b ret=%0d expected ctl=%b ret=%0d",
                         name, d, i, vec[d], ret[d], exp_q[i], mret[d]);
            end
        end
        if (retires) mret[d] = mret[d] + 4'd1;
        @(posedge clk);
        #1;
        vectors++;
        if (ret[d] !== mret[d]) begin
            miscompares++;
            $display("FAIL %s retired d%0d: got %0d expected %0d", name, d, ret[d], mret[d]);
        end
    endtask

    task automatic test_reset();
        for (int d = 0; d < 3; d++) select(d);
    endtask

    task automatic test_add();
        select(0);
        run_instr("add_lat1", 0, 6'h00, 6'h20, 1'b0, -1);
    endtask

    task automatic test_lw();
        select(2);
        run_instr("lw_lat3", 2, 6'h23, 6'h00, 1'b0, -1);
        vectors++;
        if (exp_q.size() != 9) begin
            miscompares++;
            $display("FAIL lw_len: got %0d cycles expected 9", exp_q.size());
        end
    endtask

    task automatic test_sw();
        select(1);
        run_instr("sw_lat2", 1, 6'h2B, 6'h11, 1'b1, -1);
    endtask

    task automatic test_branch_jump();
        select(0);
        run_instr("beq_z1", 0, 6'h04, 6'h00, 1'b1, -1);
        run_instr("beq_z0", 0, 6'h04, 6'h00, 1'b0, -1);
        run_instr("bne_z1", 0, 6'h05, 6'h00, 1'b1, -1);
        run_instr("bne_z0", 0, 6'h05, 6'h00, 1'b0, -1);
        run_instr("jump", 0, 6'h02, 6'h3F, 1'b0, -1);
    endtask

    task automatic test_illegal();
        select(1);
        run_instr("addi", 1, 6'h08, 6'h00, 1'b0, -1);
        run_instr("ill_op", 1, 6'h3F, 6'h20, 1'b0, -1);
        run_instr("ill_funct", 1, 6'h00, 6'h27, 1'b0, -1);
        run_instr("after_ill", 1, 6'h00, 6'h2A, 1'b0, -1);
    endtask

    task automatic test_reset_midstall();
        select(2);
        run_instr("addi_pre", 2, 6'h08, 6'h00, 1'b0, -1);
        run_instr("sw_abort", 2, 6'h2B, 6'h00, 1'b0, 6);
        select(2);
        run_instr("sw_fresh", 2, 6'h2B, 6'h00, 1'b0, -1);
    endtask

    task automatic test_wrap();
        select(0);
        for (int k = 0; k < 16; k++) run_instr("wrap", 0, 6'h08, 6'h00, 1'b0, -1);
        vectors++;
        if (ret[0] !== 4'd0) begin
            miscompares++;
            $display("FAIL wrap16: got %0d expected 0", ret[0]);
        end
    endtask

    task automatic test_random();
        logic [5:0] ops[10];
        logic [5:0] fns[6];
        ops = '{6'h00, 6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h23, 6'h2B, 6'h3F, 6'h00};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00};
        for (int s = 0; s < 8; s++) begin
            int d;
            d = $urandom_range(0, 2);
            select(d);
            for (int k = 0; k < 8; k++) begin
                logic [5:0] o, f;
                o = ops[$urandom_range(0, 9)];
                if (o == 6'h3F) o = 6'($urandom);
                f = fns[$urandom_range(0, 5)];
                if (f == 6'h00) f = 6'($urandom);
                run_instr("random", d, o, f, 1'($urandom), -1);
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; op[k] = 6'h00; funct[k] = 6'h00; zero[k] = 1'b0; mret[k] = 4'd0;
        end
        test_reset();
        test_add();
        test_lw();
        test_sw();
        test_branch_jump();
        test_illegal();
        test_reset_midstall();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
MIPS_MULTICYCLE_CTRL -- requirements
Module: mips_multicycle_ctrl

Interface
REQ-001 Parameter MEM_LAT, default 1: cycles per memory access (FETCH, MEMRD, MEMWR); legal range 1..15.
REQ-002 Parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 Op  input  6  instruction opcode, Instr[31:26] from the instruction register.
REQ-006 Funct  input  6  Instr[5:0].
REQ-007 Zero  input  1  ALU zero flag.
REQ-008 IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA  output  1 each  datapath controls.
REQ-009 ALUSrcB, PCSrc  output  2 each  mux selects.
REQ-010 ALUControl  output  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
REQ-011 PCEn  output  1  PC register enable.
REQ-012 Illegal  output  1  one-cycle pulse in DECODE on an unsupported opcode/funct.
REQ-013 Retired  output  CNT_W  count of completed instructions.

Function
REQ-014 FSM states: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP.
REQ-015 FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUControl=add, PCSrc=00; IRWrite and PCWrite only in the final (MEM_LAT-th) cycle of the access; then go to DECODE.
REQ-016 DECODE: ALUSrcA=0, ALUSrcB=11, ALUControl=add (branch target).
REQ-017 DECODE next state: LW/SW (0x23/0x2B) -> MEMADR; R-type (0x00) -> EXECUTE; BEQ (0x04)/BNE (0x05) -> BRANCH; ADDI (0x08) -> ADDIEX; J (0x02) -> JUMP; any other value -> FETCH with Illegal=1.
REQ-018 R-type funct: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt. Any other funct -> Illegal=1 in DECODE and go to FETCH.
REQ-019 MEMADR: ALUSrcA=1, ALUSrcB=10, add; LW -> MEMRD, SW -> MEMWR.
REQ-020 MEMRD: IorD=1 for MEM_LAT cycles, then MEMWB.
REQ-021 MEMWB: RegDst=0, MemtoReg=1, RegWrite=1.
REQ-022 MEMWR: IorD=1 for MEM_LAT cycles; MemWrite=1 only in the final cycle.
REQ-023 EXECUTE: ALUSrcA=1, ALUSrcB=00, funct-decoded ALUControl; then ALUWB: RegDst=1, MemtoReg=0, RegWrite=1.
REQ-024 BRANCH: ALUSrcA=1, ALUSrcB=00, sub, PCSrc=01; PCEn=Zero for BEQ, ~Zero for BNE.
REQ-025 ADDIEX: ALUSrcA=1, ALUSrcB=10, add; then ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1.
REQ-026 JUMP: PCSrc=10, PCEn=1.
REQ-027 MEMWB, MEMWR (final cycle), ALUWB, BRANCH, ADDIWB and JUMP return to FETCH.
REQ-028 Outputs not listed for a state are 0 in that state; outputs are a combinational function of state, the wait counter and Op/Funct/Zero.
REQ-029 PCEn = PCWrite | branch-taken; PCEn never asserts outside FETCH's final cycle, BRANCH or JUMP.
REQ-030 Wait counter counts 0..MEM_LAT-1 in memory states and clears on every state exit. With MEM_LAT=1 there are no stall cycles.
REQ-031 Retired increments by 1 on the cycle the FSM leaves MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB or JUMP; it is not incremented for illegal instructions; it wraps modulo 2^CNT_W.

Reset
REQ-032 While reset=1: state=FETCH, wait counter=0, Retired=0; outputs take the FETCH cycle-0 values (IRWrite=0, PCEn=0, MemWrite=0, RegWrite=0).
REQ-033 Reset asserted mid-instruction (including mid-stall) aborts the instruction with no RegWrite, MemWrite or PCEn pulse; release starts a fresh FETCH.

Structure
REQ-034 State enum, ALUControl codes, opcode and funct constants go in the shared package mips_pkg.
REQ-035 ALU decode is one sub-module, mips_aludec (ALUOp, Funct -> ALUControl, Illegal).

Verification
REQ-036 MEM_LAT=1, ADD (Op=0, Funct=0x20): states FETCH, DECODE, EXECUTE, ALUWB; RegWrite=1 and RegDst=1 in cycle 4; Retired 0->1.
REQ-037 MEM_LAT=3, LW: 3 FETCH cycles with IRWrite on the 3rd only; 3 MEMRD cycles; MEMWB with MemtoReg=1; instruction takes 9 cycles.
REQ-038 MEM_LAT=2, SW: exactly one MemWrite pulse, in the 2nd MEMWR cycle; no RegWrite.
REQ-039 BEQ with Zero=1 -> PCEn=1 and PCSrc=01 in BRANCH; BNE with Zero=1 -> PCEn=0; J -> PCSrc=10, PCEn=1.
REQ-040 Op=0x3F -> Illegal pulse in DECODE, next state FETCH, Retired unchanged; Funct=0x27 -> same behaviour.
REQ-041 Reset asserted in the 2nd MEMWR cycle with MEM_LAT=3 -> no MemWrite, state FETCH, Retired=0; CNT_W=4 after 16 retirements -> Retired=0.
